// File: rtl/timer_pkg.sv
// Register map, FSM state encoding and shared constants for timer_master.
package timer_pkg;

    localparam logic [1:0] REG_ROUNDS    = 2'b00;
    localparam logic [1:0] REG_PRESCALER = 2'b01;
    localparam logic [1:0] REG_START     = 2'b10;
    localparam logic [1:0] REG_DONE      = 2'b11;

    localparam int DONE_BIT = 0;

    // Wide enough for any DATA_W in use; the top slices off what it needs.
    localparam int                 ABORT_W         = 64;
    localparam logic [ABORT_W-1:0] ABORT_PRESCALER = '1;

    typedef enum logic [2:0] {
        IDLE,
        WR_PRE,
        WR_ROUNDS,
        WR_START,
        POLL,
        GAP,
        ABORT
    } state_t;

endpackage

// File: rtl/timer_master.sv
// Bus initiator that programs one timer peripheral and polls its DONE flag.
// Optional poll-phase timeout is enabled with TIMER_MASTER_TIMEOUT_EN.
module timer_master
    import timer_pkg::*;
#(
    parameter int          DATA_W         = 16,
    parameter int          POLL_GAP       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_rounds,
    input  logic [DATA_W-1:0] req_prescaler,
    input  logic              abort,
    output logic              busy,
    output logic              done_pulse,
    output logic              aborted,
    output logic              timeout_err,
    output logic              tmr_cs,
    output logic              tmr_we,
    output logic [1:0]        tmr_reg_sel,
    output logic [DATA_W-1:0] tmr_wdata,
    input  logic [DATA_W-1:0] tmr_rdata
);

    localparam int               GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (POLL_GAP > 1) ? GAP_W'(POLL_GAP - 1) : '0;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] rounds_q;
    logic [DATA_W-1:0] prescaler_q;
    logic [GAP_W-1:0]  gap_cnt;
    logic              accept;
    logic              poll_hit;
    logic              tmo_hit;
    logic              rdata_unused;

    // Request handshake: a transfer happens on a clock edge where req_valid and
    // req_ready are both high; req_ready is high exactly while the FSM is IDLE.
    assign req_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign accept       = req_ready && req_valid;
    assign poll_hit     = (state == POLL) && tmr_rdata[DONE_BIT];
    assign rdata_unused = ^tmr_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A poll hit outranks both abort and timeout in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) next_state = WR_PRE;
            end
            WR_PRE:    next_state = abort ? ABORT : WR_ROUNDS;
            WR_ROUNDS: next_state = abort ? ABORT : WR_START;
            WR_START:  next_state = abort ? ABORT : POLL;
            POLL: begin
                if (poll_hit)               next_state = IDLE;
                else if (abort || tmo_hit)  next_state = ABORT;
                else if (POLL_GAP > 0)      next_state = GAP;
            end
            GAP: begin
                if (abort || tmo_hit)       next_state = ABORT;
                else if (gap_cnt == '0)     next_state = POLL;
            end
            ABORT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus outputs depend on registered state and latched goals only.
    always_comb begin
        tmr_cs      = 1'b0;
        tmr_we      = 1'b0;
        tmr_reg_sel = REG_ROUNDS;
        tmr_wdata   = '0;
        case (state)
            WR_PRE: begin
                tmr_cs      = 1'b1;
                tmr_we      = 1'b1;
                tmr_reg_sel = REG_PRESCALER;
                tmr_wdata   = prescaler_q;
            end
            WR_ROUNDS: begin
                tmr_cs      = 1'b1;
                tmr_we      = 1'b1;
                tmr_reg_sel = REG_ROUNDS;
                tmr_wdata   = rounds_q;
            end
            WR_START: begin
                tmr_cs      = 1'b1;
                tmr_we      = 1'b1;
                tmr_reg_sel = REG_START;
            end
            POLL: begin
                tmr_cs      = 1'b1;
                tmr_reg_sel = REG_DONE;
            end
            ABORT: begin
                tmr_cs      = 1'b1;
                tmr_we      = 1'b1;
                tmr_reg_sel = REG_PRESCALER;
                tmr_wdata   = ABORT_PRESCALER[DATA_W-1:0];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rounds_q    <= '0;
            prescaler_q <= '0;
        end else if (accept) begin
            rounds_q    <= req_rounds;
            prescaler_q <= req_prescaler;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (state == POLL) begin
            gap_cnt <= GAP_LOAD;
        end else if ((state == GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_pulse <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done_pulse <= poll_hit;
            aborted    <= (state == ABORT);
        end
    end

`ifdef TIMER_MASTER_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] tmo_cnt;
    logic        tmo_cause;
    logic        timeout_q;

    // tmo_cnt holds the number of poll-phase cycles already spent.
    assign tmo_hit     = ((state == POLL) || (state == GAP)) && (tmo_cnt == TMO_LAST);
    assign timeout_err = timeout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt   <= '0;
            tmo_cause <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (state == WR_START) begin
                tmo_cnt <= '0;
            end else if ((state == POLL) || (state == GAP)) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
            tmo_cause <= tmo_hit && (next_state == ABORT);
            timeout_q <= (state == ABORT) && tmo_cause;
        end
    end
`else
    logic tmo_unused;

    assign tmo_hit     = 1'b0;
    assign tmo_unused  = (TIMEOUT_CYCLES == 0);
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_timer_master.sv
// Bench for timer_master: two instances (POLL_GAP 0 and 2) each driving a behavioural timer.
`timescale 1ns/1ps
module tb_timer_master;
  import timer_pkg::*;

  localparam int DW  = 16;
  localparam int EW  = 25;
  localparam int TMO = 8;
`ifdef TIMER_MASTER_TIMEOUT_EN
  localparam bit TMO_EN         = 1'b1;
  localparam int EXP_LONG_DONE  = -1;
  localparam int EXP_LONG_ABORT = 13;
`else
  localparam bit TMO_EN         = 1'b0;
  localparam int EXP_LONG_DONE  = 105;
  localparam int EXP_LONG_ABORT = -1;
`endif
  localparam logic [EW-1:0] IDLE_V = {1'b1, 24'h0};

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          req_valid[2], req_ready[2], abort[2], busy[2];
  logic          done_pulse[2], aborted[2], timeout_err[2], tmr_cs[2], tmr_we[2];
  logic [DW-1:0] req_rounds[2], req_prescaler[2], tmr_wdata[2], tmr_rdata[2];
  logic [1:0]    tmr_reg_sel[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    timer_master #(.DATA_W(DW), .POLL_GAP(g * 2), .TIMEOUT_CYCLES(TMO)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_rounds(req_rounds[g]), .req_prescaler(req_prescaler[g]),
      .abort(abort[g]), .busy(busy[g]),
      .done_pulse(done_pulse[g]), .aborted(aborted[g]), .timeout_err(timeout_err[g]),
      .tmr_cs(tmr_cs[g]), .tmr_we(tmr_we[g]), .tmr_reg_sel(tmr_reg_sel[g]),
      .tmr_wdata(tmr_wdata[g]), .tmr_rdata(tmr_rdata[g])
    );
  end

  // behavioural timer: START loads rounds; one round per (prescaler+1) cycles; prescaler=FFFF freezes
  logic [DW-1:0] t_rounds[2], t_pre[2], t_rem[2], t_pcnt[2];
  logic          t_run[2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        t_rounds[i] <= '0; t_pre[i] <= '0; t_rem[i] <= '0; t_pcnt[i] <= '0; t_run[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (tmr_cs[i] && tmr_we[i]) begin
          case (tmr_reg_sel[i])
            REG_PRESCALER: begin
              t_pre[i] <= tmr_wdata[i];
              if (tmr_wdata[i] == 16'hFFFF) t_run[i] <= 1'b0;
            end
            REG_ROUNDS: t_rounds[i] <= tmr_wdata[i];
            REG_START: begin
              t_rem[i]  <= t_rounds[i];
              t_pcnt[i] <= t_pre[i];
              t_run[i]  <= (t_rounds[i] != 16'd0);
            end
            default: ;
          endcase
        end else if (t_run[i]) begin
          if (t_pcnt[i] == 16'd0) begin
            t_rem[i]  <= t_rem[i] - 16'd1;
            t_pcnt[i] <= t_pre[i];
            if (t_rem[i] == 16'd1) t_run[i] <= 1'b0;
          end else begin
            t_pcnt[i] <= t_pcnt[i] - 16'd1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) tmr_rdata[i] = {15'h2AAA, (t_rem[i] == 16'd0)};
  end

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] cmp_e, cmp_a;

  function automatic logic [EW-1:0] pk(input logic rdy, input logic bsy, input logic cs, input logic we,
                                       input logic [1:0] sel, input logic [DW-1:0] wd,
                                       input logic dn, input logic ab, input logic to);
    return {rdy, bsy, cs, we, sel, wd, dn, ab, to};
  endfunction

  function automatic logic [EW-1:0] act_vec(input int i);
    return {req_ready[i], busy[i], tmr_cs[i], tmr_we[i], tmr_reg_sel[i], tmr_wdata[i],
            done_pulse[i], aborted[i], timeout_err[i]};
  endfunction

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      for (int i = 0; i < 2; i++) begin
        cmp_e = IDLE_V;
        if (i == 0 && exp_q0.size() > 0) cmp_e = exp_q0.pop_front();
        if (i == 1 && exp_q1.size() > 0) cmp_e = exp_q1.pop_front();
        cmp_a = act_vec(i);
        n_checks++;
        if (cmp_a !== cmp_e) begin
          n_fail++;
          $display("FAIL bus_trace inst%0d t=%0t actual=%h required=%h", i, $time, cmp_a, cmp_e);
        end
      end
    end
  end

  // driver: builds the expected per-cycle trace from the request schedule, then plays the request
  task automatic send(input int i, input logic [DW-1:0] r, input logic [DW-1:0] p,
                      input int abort_at, input int hold, input int stop_at,
                      output int done_k, output int abort_k);
    logic [EW-1:0] tr[$];
    logic [EW-1:0] e;
    int  g, done_at, k;
    bit  poll, hit, tmo, fin;
    g       = (i == 0) ? 0 : 2;
    done_at = 4 + int'(r) * (int'(p) + 1);
    fin     = 1'b0;
    tr.push_back(IDLE_V);
    for (k = 1; k < 3000 && !fin; k++) begin
      poll = (k >= 4) && (((k - 4) % (g + 1)) == 0);
      if (k == 1)      e = pk(1'b0, 1'b1, 1'b1, 1'b1, REG_PRESCALER, p, 1'b0, 1'b0, 1'b0);
      else if (k == 2) e = pk(1'b0, 1'b1, 1'b1, 1'b1, REG_ROUNDS, r, 1'b0, 1'b0, 1'b0);
      else if (k == 3) e = pk(1'b0, 1'b1, 1'b1, 1'b1, REG_START, 16'h0, 1'b0, 1'b0, 1'b0);
      else if (poll)   e = pk(1'b0, 1'b1, 1'b1, 1'b0, REG_DONE, 16'h0, 1'b0, 1'b0, 1'b0);
      else             e = pk(1'b0, 1'b1, 1'b0, 1'b0, REG_ROUNDS, 16'h0, 1'b0, 1'b0, 1'b0);
      tr.push_back(e);
      hit = poll && (k >= done_at);
      tmo = TMO_EN && (k >= 4) && ((k - 3) == TMO);
      if (hit) begin
        tr.push_back(pk(1'b1, 1'b0, 1'b0, 1'b0, REG_ROUNDS, 16'h0, 1'b1, 1'b0, 1'b0));
        fin = 1'b1;
      end else if (k == abort_at || tmo) begin
        tr.push_back(pk(1'b0, 1'b1, 1'b1, 1'b1, REG_PRESCALER, 16'hFFFF, 1'b0, 1'b0, 1'b0));
        tr.push_back(pk(1'b1, 1'b0, 1'b0, 1'b0, REG_ROUNDS, 16'h0, 1'b0, 1'b1, tmo));
        fin = 1'b1;
      end
    end
    chk_int("model_bound", int'(fin), 1);
    done_k  = -1;
    abort_k = -1;
    @(posedge clk); #1;
    foreach (tr[j]) begin
      if (i == 0) exp_q0.push_back(tr[j]);
      else        exp_q1.push_back(tr[j]);
    end
    req_valid[i] = 1'b1; req_rounds[i] = r; req_prescaler[i] = p;
    for (int c = 1; c < tr.size(); c++) begin
      @(posedge clk); #1;
      req_valid[i] = (c <= hold); req_rounds[i] = 16'hDEAD; req_prescaler[i] = 16'hBEEF;
      abort[i] = (c == abort_at);
      if (done_pulse[i]) done_k = c;
      if (aborted[i])    abort_k = c;
      if (c == stop_at) begin
        #2 reset = 1'b1;
        #1;
        chk_int("reset_drops_cs", int'(tmr_cs[i]), 0);
        chk_int("reset_clears_busy", int'(busy[i]), 0);
        if (i == 0) exp_q0.delete(); else exp_q1.delete();
        @(posedge clk); #2 reset = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    abort[i] = 1'b0; req_valid[i] = 1'b0;
  endtask

  initial begin
    int dk, ak;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; abort[i] = 1'b0; req_rounds[i] = '0; req_prescaler[i] = '0;
    end
    #12;
    chk_vec("reset_state0", act_vec(0), IDLE_V);
    chk_vec("reset_state1", act_vec(1), IDLE_V);
    @(posedge clk); #2 reset = 1'b0; chk_en = 1'b1;
    repeat (2) @(posedge clk);

    send(0, 16'd0, 16'd5, 0, 0, 0, dk, ak);
    chk_int("r0_done_cycle", dk, 5); chk_int("r0_no_abort", ak, -1);

    send(0, 16'd1, 16'd0, 0, 0, 0, dk, ak);
    chk_int("r1_done_cycle", dk, 6);

    send(1, 16'd3, 16'd1, 0, 0, 0, dk, ak);
    chk_int("gap_done_cycle", dk, 11); chk_int("gap_no_abort", ak, -1);

    send(0, 16'd50, 16'd0, 5, 0, 0, dk, ak);
    chk_int("abort_poll_cycle", ak, 7); chk_int("abort_poll_no_done", dk, -1);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      chk_int("abort_timer_frozen", int'(tmr_rdata[0][0]), 0);
    end

    send(0, 16'd1, 16'd0, 5, 3, 0, dk, ak);
    chk_int("hit_vs_abort_done", dk, 6); chk_int("hit_vs_abort_no_abort", ak, -1);

    send(1, 16'd20, 16'd0, 5, 0, 0, dk, ak);
    chk_int("abort_in_gap", ak, 7);

    send(0, 16'd9, 16'd2, 2, 0, 0, dk, ak);
    chk_int("abort_in_write", ak, 4);

    @(posedge clk); #1;
    abort[0] = 1'b1; abort[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 abort[0] = 1'b0; abort[1] = 1'b0;

    send(0, 16'd100, 16'd0, 0, 0, 0, dk, ak);
    chk_int("long_done", dk, EXP_LONG_DONE); chk_int("long_abort", ak, EXP_LONG_ABORT);

    send(0, 16'd100, 16'd0, 0, 0, 6, dk, ak);
    repeat (2) @(posedge clk);

    send(0, 16'd0, 16'd5, 0, 0, 0, dk, ak);
    chk_int("after_reset_done", dk, 5);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
